// File: rtl/eth_pkg.sv
`default_nettype none
// ============================================================================
//  Package     : eth_pkg
//  Description : Shared constants, receive state encoding and the byte-wide
//                CRC-32 next-state function for the Ethernet receive path.
//  Revision    : 1.0 - initial release
// ============================================================================
package eth_pkg;

    localparam logic [7:0]  ETH_PREAMBLE  = 8'h55;
    localparam logic [7:0]  ETH_SFD       = 8'hD5;

    localparam logic [31:0] CRC32_POLY    = 32'h04C1_1DB7;
    localparam logic [31:0] CRC32_INIT    = 32'hFFFF_FFFF;
    localparam logic [31:0] CRC32_RESIDUE = 32'hC704_DD7B;

    typedef enum logic [1:0] {
        ST_IDLE     = 2'd0,
        ST_PREAMBLE = 2'd1,
        ST_DATA     = 2'd2,
        ST_DROP     = 2'd3
    } rx_state_t;

    // MSB-first register, byte consumed LSB-first (wire order on the line)
    function automatic logic [31:0] crc32_d8_next(input logic [31:0] crc,
                                                  input logic [7:0]  data);
        logic [31:0] c;
        logic        fb;
        c = crc;
        for (int i = 0; i < 8; i++) begin
            fb = c[31] ^ data[i];
            c  = {c[30:0], 1'b0} ^ (fb ? CRC32_POLY : 32'h0);
        end
        return c;
    endfunction

endpackage
`default_nettype wire

// File: rtl/eth_rx_crc32_d8.sv
`default_nettype none
// ============================================================================
//  Module      : eth_rx_crc32_d8
//  Description : Byte-wide CRC-32 register. The raw (non-reflected,
//                non-inverted) register is exposed for residue comparison.
//  Revision    : 1.0 - initial release
// ============================================================================
module eth_rx_crc32_d8
    import eth_pkg::*;
(
    input  logic        clk,
    input  logic        reset,
    input  logic        i_init,
    input  logic        i_en,
    input  logic [7:0]  i_data,
    output logic [31:0] o_crc
);

    logic [31:0] r_crc;

    // CRC register: init has priority over a data update
    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            r_crc <= CRC32_INIT;
        end else if (i_init) begin
            r_crc <= CRC32_INIT;
        end else if (i_en) begin
            r_crc <= crc32_d8_next(r_crc, i_data);
        end
    end

    assign o_crc = r_crc;

endmodule
`default_nettype wire

// File: rtl/eth_rx_fcs_check.sv
`default_nettype none
// ============================================================================
//  Module      : eth_rx_fcs_check
//  Description : GMII receive frame checker. Strips preamble/SFD, checks the
//                CRC-32 over DA..FCS, strips the FCS from the payload stream
//                and reports per-frame status (crc, runt, giant, phy error).
//  Revision    : 1.0 - initial release
// ============================================================================
module eth_rx_fcs_check
    import eth_pkg::*;
#(
    parameter int MIN_FRAME_LEN = 64,
    parameter int MAX_FRAME_LEN = 1518,
    parameter int CNT_W         = 11
) (
    input  logic             clk,
    input  logic             reset,
    input  logic             gmii_rx_dv,
    input  logic             gmii_rx_er,
    input  logic [7:0]       gmii_rxd,
    output logic             out_valid,
    output logic [7:0]       out_data,
    output logic             out_sof,
    output logic             frame_done,
    output logic             frame_ok,
    output logic             crc_ok,
    output logic             runt,
    output logic             giant,
    output logic             phy_err,
    output logic [CNT_W-1:0] frame_len
);

    localparam logic [CNT_W-1:0] c_min_len = CNT_W'(MIN_FRAME_LEN);
    localparam logic [CNT_W-1:0] c_max_len = CNT_W'(MAX_FRAME_LEN);
    localparam logic [CNT_W-1:0] c_cnt_max = '1;
    localparam logic [CNT_W-1:0] c_fcs_len = CNT_W'(4);

    logic             r_dv;
    logic             r_er;
    logic [7:0]       r_rxd;

    rx_state_t        r_state;
    logic [CNT_W-1:0] r_cnt;
    logic [3:0][7:0]  r_dly;
    logic             r_err;

    logic             w_crc_init;
    logic             w_crc_en;
    logic [31:0]      w_crc;
    logic             w_crc_ok;
    logic             w_runt;
    logic             w_giant;
    logic             w_phy_err;

    // Single register stage on every GMII input
    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            r_dv  <= 1'b0;
            r_er  <= 1'b0;
            r_rxd <= 8'h00;
        end else begin
            r_dv  <= gmii_rx_dv;
            r_er  <= gmii_rx_er;
            r_rxd <= gmii_rxd;
        end
    end

    assign w_crc_init = (r_state == ST_PREAMBLE) && r_dv && (r_rxd == ETH_SFD);
    assign w_crc_en   = (r_state == ST_DATA) && r_dv;

    eth_rx_crc32_d8 u_crc (
        .clk    (clk),
        .reset  (reset),
        .i_init (w_crc_init),
        .i_en   (w_crc_en),
        .i_data (r_rxd),
        .o_crc  (w_crc)
    );

    // End-of-frame verdicts, evaluated on the cycle dv is seen low in DATA
    assign w_crc_ok  = (w_crc == CRC32_RESIDUE);
    assign w_runt    = (r_cnt < c_min_len);
    assign w_giant   = (r_cnt > c_max_len);
    assign w_phy_err = r_err | r_er;

    // Receive state machine, byte counter, FCS delay line and all outputs
    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            r_state    <= ST_IDLE;
            r_cnt      <= '0;
            r_dly      <= '0;
            r_err      <= 1'b0;
            out_valid  <= 1'b0;
            out_data   <= 8'h00;
            out_sof    <= 1'b0;
            frame_done <= 1'b0;
            frame_ok   <= 1'b0;
            crc_ok     <= 1'b0;
            runt       <= 1'b0;
            giant      <= 1'b0;
            phy_err    <= 1'b0;
            frame_len  <= '0;
        end else begin
            out_valid  <= 1'b0;
            out_sof    <= 1'b0;
            frame_done <= 1'b0;
            case (r_state)
                ST_IDLE: begin
                    if (r_dv) begin
                        r_state <= (r_rxd == ETH_PREAMBLE) ? ST_PREAMBLE : ST_DROP;
                    end
                end
                ST_PREAMBLE: begin
                    if (!r_dv) begin
                        r_state <= ST_IDLE;
                    end else if (r_rxd == ETH_SFD) begin
                        r_state <= ST_DATA;
                        r_cnt   <= '0;
                        r_err   <= 1'b0;
                    end else if (r_rxd != ETH_PREAMBLE) begin
                        r_state <= ST_DROP;
                    end
                end
                ST_DATA: begin
                    if (r_er) begin
                        r_err <= 1'b1;
                    end
                    if (r_dv) begin
                        if (r_cnt != c_cnt_max) begin
                            r_cnt <= r_cnt + CNT_W'(1);
                        end
                        r_dly <= {r_dly[2:0], r_rxd};
                        // Four newer bytes now exist, so the oldest is not FCS
                        if (r_cnt >= c_fcs_len) begin
                            out_valid <= 1'b1;
                            out_data  <= r_dly[3];
                            out_sof   <= (r_cnt == c_fcs_len);
                        end
                    end else begin
                        r_state    <= ST_IDLE;
                        frame_done <= 1'b1;
                        frame_len  <= r_cnt;
                        crc_ok     <= w_crc_ok;
                        runt       <= w_runt;
                        giant      <= w_giant;
                        phy_err    <= w_phy_err;
                        frame_ok   <= w_crc_ok & ~w_runt & ~w_giant & ~w_phy_err;
                    end
                end
                ST_DROP: begin
                    if (!r_dv) begin
                        r_state <= ST_IDLE;
                    end
                end
                default: r_state <= ST_IDLE;
            endcase
        end
    end

endmodule
`default_nettype wire

// File: tb/tb_eth_rx_fcs_check.sv
`default_nettype none
// ============================================================================
//  Module      : tb_eth_rx_fcs_check
//  Description : Self-checking bench for eth_rx_fcs_check. Frames are built in
//                a byte queue; expected payload bytes and status come from a
//                reflected-CRC reference model and are matched on the output.
//  Revision    : 1.0 - initial release
// ============================================================================
module tb_eth_rx_fcs_check;

    logic        clk = 1'b0;
    logic        reset = 1'b1;
    logic        gmii_rx_dv = 1'b0;
    logic        gmii_rx_er = 1'b0;
    logic [7:0]  gmii_rxd = 8'h00;
    logic        out_valid;
    logic [7:0]  out_data;
    logic        out_sof;
    logic        frame_done;
    logic        frame_ok;
    logic        crc_ok;
    logic        runt;
    logic        giant;
    logic        phy_err;
    logic [10:0] frame_len;

    eth_rx_fcs_check #(
        .MIN_FRAME_LEN (64),
        .MAX_FRAME_LEN (1518),
        .CNT_W         (11)
    ) dut (
        .clk        (clk),
        .reset      (reset),
        .gmii_rx_dv (gmii_rx_dv),
        .gmii_rx_er (gmii_rx_er),
        .gmii_rxd   (gmii_rxd),
        .out_valid  (out_valid),
        .out_data   (out_data),
        .out_sof    (out_sof),
        .frame_done (frame_done),
        .frame_ok   (frame_ok),
        .crc_ok     (crc_ok),
        .runt       (runt),
        .giant      (giant),
        .phy_err    (phy_err),
        .frame_len  (frame_len)
    );

    always #4 clk = ~clk;

    int cyc = 0;
    always @(posedge clk) cyc <= cyc + 1;

    typedef struct packed { logic [7:0] d; logic sof; int t; } exp_b_t;
    typedef struct packed { logic [15:0] st; int t; } exp_s_t;

    exp_b_t      q_b[$];
    exp_s_t      q_s[$];
    logic [7:0]  frm[$];
    logic [15:0] held = 16'h0;
    int          n_cmp = 0;
    int          n_err = 0;

    task automatic check_eq(input string tag, input logic [63:0] got, input logic [63:0] exp);
        n_cmp++;
        if (got !== exp) begin
            n_err++;
            $display("FAIL %s: got %0h expected %0h (cyc %0d)", tag, got, exp, cyc);
        end
    endtask

    // Reflected (LSB-first) CRC-32 over the first n bytes of frm, no final xor
    function automatic logic [31:0] crc_refl(input int n);
        logic [31:0] c = 32'hFFFF_FFFF;
        for (int i = 0; i < n; i++) begin
            c = c ^ {24'h0, frm[i]};
            for (int b = 0; b < 8; b++) c = c[0] ? ((c >> 1) ^ 32'hEDB8_8320) : (c >> 1);
        end
        return c;
    endfunction

    task automatic append_fcs();
        logic [31:0] f;
        f = ~crc_refl(frm.size());
        frm.push_back(f[7:0]);  frm.push_back(f[15:8]);
        frm.push_back(f[23:16]); frm.push_back(f[31:24]);
    endtask

    // Status word {phy_err, giant, runt, crc_ok, frame_ok, frame_len}
    function automatic logic [15:0] exp_status(input logic er);
        int          n = frm.size();
        int          len = (n > 2047) ? 2047 : n;
        logic        c_ok = (crc_refl(n) == 32'hDEBB_20E3);
        logic        r = (len < 64);
        logic        g = (len > 1518);
        logic        ok = c_ok && !r && !g && !er;
        logic [10:0] l = len[10:0];
        return {er, g, r, c_ok, ok, l};
    endfunction

    task automatic drive(input logic dv, input logic er, input logic [7:0] d);
        @(negedge clk);
        gmii_rx_dv = dv;
        gmii_rx_er = er;
        gmii_rxd   = d;
    endtask

    task automatic do_abort();
        @(negedge clk);
        #2;
        reset    = 1'b1;
        gmii_rxd = 8'h00;
        held     = 16'h0;
        #1;
        check_eq("abort_valid", 64'(out_valid), 64'd0);
        check_eq("abort_done", 64'(frame_done), 64'd0);
        check_eq("abort_len", 64'(frame_len), 64'd0);
        repeat (3) @(negedge clk);
        reset = 1'b0;
        repeat (10) drive(1'b1, 1'b0, 8'h00);
        repeat (3) drive(1'b0, 1'b0, 8'h00);
    endtask

    // Sends frm with preamble; pushes model expectations as bytes go out
    task automatic send_frame(input int pre_len, input int er_idx, input int abort_at, input int gap);
        int n = frm.size();
        for (int p = 0; p < pre_len; p++) drive(1'b1, 1'b0, 8'h55);
        drive(1'b1, 1'b0, 8'hD5);
        for (int i = 0; i < n; i++) begin
            if (i == abort_at) begin
                do_abort();
                return;
            end
            drive(1'b1, (i == er_idx), frm[i]);
            if (n >= 5 && i <= n - 5 && (abort_at < 0 || i <= abort_at - 6))
                q_b.push_back('{d: frm[i], sof: (i == 0), t: cyc + 6});
        end
        drive(1'b0, 1'b0, 8'h00);
        q_s.push_back('{st: exp_status(er_idx >= 0 && er_idx < n), t: cyc + 2});
        for (int g = 1; g < gap; g++) drive(1'b0, 1'b0, 8'h00);
    endtask

    task automatic build_good64();
        frm.delete();
        for (int i = 0; i < 60; i++) frm.push_back(8'(i));
        append_fcs();
    endtask

    exp_b_t eb;
    exp_s_t es;

    // Output monitor: every valid byte and status strobe is matched to the model
    always @(negedge clk) begin
        if (!reset) begin
            if (out_valid) begin
                if (q_b.size() == 0) begin
                    check_eq("spurious_byte", 64'(out_data) | 64'h100, 64'd0);
                end else begin
                    eb = q_b.pop_front();
                    check_eq("data", 64'(out_data), 64'(eb.d));
                    check_eq("sof", 64'(out_sof), 64'(eb.sof));
                    check_eq("byte_cycle", 64'(cyc), 64'(eb.t));
                end
                if (!frame_done)
                    check_eq("status_hold", 64'({phy_err, giant, runt, crc_ok, frame_ok, frame_len}), 64'(held));
            end
            if (frame_done) begin
                if (q_s.size() == 0) begin
                    check_eq("spurious_done", 64'(frame_done), 64'd0);
                end else begin
                    es = q_s.pop_front();
                    check_eq("status", 64'({phy_err, giant, runt, crc_ok, frame_ok, frame_len}), 64'(es.st));
                    check_eq("done_cycle", 64'(cyc), 64'(es.t));
                    held = es.st;
                end
            end
        end
    end

    initial begin
        int n, er_idx, flip;
        repeat (3) @(negedge clk);
        check_eq("rst_valid", 64'(out_valid), 64'd0);
        check_eq("rst_data", 64'(out_data), 64'd0);
        check_eq("rst_sof", 64'(out_sof), 64'd0);
        check_eq("rst_done", 64'(frame_done), 64'd0);
        check_eq("rst_status", 64'({phy_err, giant, runt, crc_ok, frame_ok, frame_len}), 64'd0);
        reset = 1'b0;
        repeat (2) drive(1'b0, 1'b0, 8'h00);

        // "123456789" with its known FCS
        frm.delete();
        for (int i = 0; i < 9; i++) frm.push_back(8'h31 + 8'(i));
        frm.push_back(8'h26); frm.push_back(8'h39); frm.push_back(8'hF4); frm.push_back(8'hCB);
        send_frame(7, -1, -1, 2);

        // Minimum-size good frame
        build_good64();
        send_frame(7, -1, -1, 2);

        // Bit error in payload byte 10
        build_good64();
        frm[10] = frm[10] ^ 8'h04;
        send_frame(7, -1, -1, 2);

        // Giant with good FCS, single-cycle gap, then good frame
        frm.delete();
        for (int i = 0; i < 1515; i++) frm.push_back(8'($urandom));
        append_fcs();
        send_frame(7, -1, -1, 1);
        build_good64();
        send_frame(7, -1, -1, 2);

        // PHY error at byte 20
        build_good64();
        send_frame(7, 20, -1, 2);

        // Bad preamble byte, dv held
        drive(1'b1, 1'b0, 8'h55); drive(1'b1, 1'b0, 8'h55); drive(1'b1, 1'b0, 8'h0A);
        repeat (10) drive(1'b1, 1'b0, 8'($urandom));
        repeat (2) drive(1'b0, 1'b0, 8'h00);

        // Reset in the middle of DATA, then a good frame
        build_good64();
        send_frame(7, -1, 20, 2);
        build_good64();
        send_frame(7, -1, -1, 2);

        // Randomized frames
        for (int f = 0; f < 30; f++) begin
            frm.delete();
            n = $urandom_range(0, 90);
            for (int i = 0; i < n; i++) frm.push_back(8'($urandom));
            if ($urandom_range(0, 3) != 0) append_fcs();
            if (frm.size() > 0 && $urandom_range(0, 5) == 0) begin
                flip = $urandom_range(0, frm.size() - 1);
                frm[flip] = frm[flip] ^ 8'h01;
            end
            er_idx = (frm.size() > 0 && $urandom_range(0, 6) == 0) ? $urandom_range(0, frm.size() - 1) : -1;
            send_frame($urandom_range(1, 7), er_idx, -1, $urandom_range(1, 3));
        end

        repeat (20) drive(1'b0, 1'b0, 8'h00);
        check_eq("bytes_left", 64'(q_b.size()), 64'd0);
        check_eq("status_left", 64'(q_s.size()), 64'd0);
        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
        $finish;
    end

endmodule
`default_nettype wire
